// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU op codes, forward selects,
// branch compare types, multiplier FSM states and the E->M bubble constant.
// Latency: n/a (types and constants only). Backpressure: n/a.
package exe_pkg;

  // ALU operation codes carried on ALUControlE.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  // Forward selects; 2'b11 falls back to the register-file value.
  localparam logic [1:0] FWD_RD = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Branch compare types (funct3); 3'b010 and 3'b011 never take.
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mulState_t;

  // Control fields of the E->M register.
  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic [1:0] resultSrc;
  } ctrlM_t;

  // A bubble has no architectural side effects.
  localparam ctrlM_t CTRL_BUBBLE = '{regWrite: 1'b0, memWrite: 1'b0, resultSrc: 2'b00};

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, low XLEN bits of a*b, one multiplier bit per cycle.
// Latency: start cycle + XLEN busy cycles, product valid while done=1 (XLEN+2 total).
// Backpressure: busy is high from the start cycle through the last iteration; start is ignored unless idle.
// Ports: clk/rst (sync, active-high); start, a, b in; busy, done, product out.
module mul_iter
  import exe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(XLEN + 1);

  mulState_t       state, nextState;
  logic [XLEN-1:0] mcand, mplier, acc;
  logic [CW-1:0]   count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MUL_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else begin
      state <= nextState;
      case (state)
        MUL_IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= CW'(XLEN);
          end
        end
        MUL_BUSY: begin
          if (mcand[0]) acc <= acc + mplier;
          mplier <= mplier << 1;
          mcand  <= mcand >> 1;
          count  <= count - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nextState = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      MUL_IDLE: begin
        if (start) begin
          busy      = 1'b1;
          nextState = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        busy = 1'b1;
        // count==1 here is the last multiplier bit; acc is final next cycle.
        if (count == CW'(1)) nextState = MUL_DONE;
      end
      MUL_DONE: begin
        done      = 1'b1;
        nextState = MUL_IDLE;
      end
      default: nextState = MUL_IDLE;
    endcase
  end

  assign product = acc;

endmodule

// File: rtl/execute_stage_fwd.sv
// RISC-V execute stage: operand forwarding, ALU, branch compare, iterative MUL, E->M register.
// Latency: 1 cycle to M for single-cycle ops; MUL occupies E for XLEN+2 cycles.
// Backpressure: StallE holds F/D/E while the multiplier runs; bubbles are loaded into M meanwhile.
// Ports: clk/rst (sync, active-high); E-stage controls, operands, PCs and forward selects in;
//        PCSrcE/PCTargetE redirect, StallE to the hazard unit, registered M-stage fields out.
module execute_stage_fwd
  import exe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter bit MUL_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              ALUSrcE,
  input  logic              BranchE,
  input  logic              JumpE,
  input  logic [1:0]        ResultSrcE,
  input  logic [3:0]        ALUControlE,
  input  logic [2:0]        BranchTypeE,
  input  logic [XLEN-1:0]   RD1_E,
  input  logic [XLEN-1:0]   RD2_E,
  input  logic [XLEN-1:0]   Imm_Ext_E,
  input  logic [XLEN-1:0]   PCE,
  input  logic [XLEN-1:0]   PCPlus4E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [1:0]        ForwardA_E,
  input  logic [1:0]        ForwardB_E,
  input  logic [XLEN-1:0]   ResultW,
  output logic              PCSrcE,
  output logic [XLEN-1:0]   PCTargetE,
  output logic              StallE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM,
  output logic [REG_AW-1:0] RD_M,
  output logic [XLEN-1:0]   PCPlus4M,
  output logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   ALU_ResultM
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] srcA, fwdB, srcB, sum, aluResult, mulProduct;
  logic [SHW-1:0]  shamt;
  logic            branchCond, isMul, mulStall, mulDone;
  ctrlM_t          ctrlE, ctrlM;

  // Forwarding muxes; ALU_ResultM is the registered M value fed back.
  always_comb begin
    case (ForwardA_E)
      FWD_W:   srcA = ResultW;
      FWD_M:   srcA = ALU_ResultM;
      default: srcA = RD1_E;
    endcase
    case (ForwardB_E)
      FWD_W:   fwdB = ResultW;
      FWD_M:   fwdB = ALU_ResultM;
      default: fwdB = RD2_E;
    endcase
  end

  assign srcB  = ALUSrcE ? Imm_Ext_E : fwdB;
  assign sum   = srcA + srcB;
  assign shamt = srcB[SHW-1:0];
  assign isMul = (ALUControlE == ALU_MUL);

  if (MUL_EN) begin : gMul
    mul_iter #(.XLEN(XLEN)) uMul (
      .clk     (clk),
      .rst     (rst),
      .start   (isMul),
      .a       (srcA),
      .b       (srcB),
      .busy    (mulStall),
      .done    (mulDone),
      .product (mulProduct)
    );
  end else begin : gNoMul
    assign mulStall   = 1'b0;
    assign mulDone    = 1'b0;
    assign mulProduct = '0;
  end

  assign StallE = mulStall;

  always_comb begin
    aluResult = '0;
    case (ALUControlE)
      ALU_ADD: aluResult = sum;
      ALU_SUB: aluResult = srcA - srcB;
      ALU_AND: aluResult = srcA & srcB;
      ALU_OR:  aluResult = srcA | srcB;
      ALU_XOR: aluResult = srcA ^ srcB;
      ALU_SLT: aluResult = {{(XLEN-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      ALU_SLL: aluResult = srcA << shamt;
      ALU_SRL: aluResult = srcA >> shamt;
      // Without the multiplier MUL decodes as ADD; with it, the product is
      // only meaningful in the DONE cycle (earlier cycles load bubbles anyway).
      ALU_MUL: aluResult = MUL_EN ? (mulDone ? mulProduct : '0) : sum;
      default: aluResult = '0;
    endcase
  end

  // Branch compare uses the forwarded rs2, never the immediate.
  always_comb begin
    case (BranchTypeE)
      BR_EQ:   branchCond = (srcA == fwdB);
      BR_NE:   branchCond = (srcA != fwdB);
      BR_LT:   branchCond = ($signed(srcA) <  $signed(fwdB));
      BR_GE:   branchCond = ($signed(srcA) >= $signed(fwdB));
      BR_LTU:  branchCond = (srcA <  fwdB);
      BR_GEU:  branchCond = (srcA >= fwdB);
      default: branchCond = 1'b0;
    endcase
  end

  assign PCSrcE    = (BranchE & branchCond) | JumpE;
  assign PCTargetE = PCE + Imm_Ext_E;

  assign ctrlE = '{regWrite: RegWriteE, memWrite: MemWriteE, resultSrc: ResultSrcE};

  always_ff @(posedge clk) begin
    if (rst || StallE) begin
      ctrlM       <= CTRL_BUBBLE;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else begin
      ctrlM       <= ctrlE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= fwdB;
      ALU_ResultM <= aluResult;
    end
  end

  assign RegWriteM  = ctrlM.regWrite;
  assign MemWriteM  = ctrlM.memWrite;
  assign ResultSrcM = ctrlM.resultSrc;

endmodule

// File: tb/tb_execute_stage_fwd.sv
module tb_execute_stage_fwd;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7,
                         OP_MUL = 4'd8;

  logic              clk = 1'b0;
  logic              rst;
  logic              RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
  logic [1:0]        ResultSrcE;
  logic [3:0]        ALUControlE;
  logic [2:0]        BranchTypeE;
  logic [XLEN-1:0]   RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [REG_AW-1:0] RD_E;
  logic [1:0]        ForwardA_E, ForwardB_E;
  logic [XLEN-1:0]   ResultW;
  logic              PCSrcE, StallE, RegWriteM, MemWriteM;
  logic [XLEN-1:0]   PCTargetE, PCPlus4M, WriteDataM, ALU_ResultM;
  logic [1:0]        ResultSrcM;
  logic [REG_AW-1:0] RD_M;

  execute_stage_fwd #(.XLEN(XLEN), .REG_AW(REG_AW), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
    .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .BranchTypeE(BranchTypeE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RD_E(RD_E), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallE(StallE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
    .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    RegWriteE = 1'b0; MemWriteE = 1'b0; ALUSrcE = 1'b0; BranchE = 1'b0; JumpE = 1'b0;
    ResultSrcE = 2'd0; ALUControlE = OP_ADD; BranchTypeE = 3'd0;
    RD1_E = '0; RD2_E = '0; Imm_Ext_E = '0; PCE = '0; PCPlus4E = '0; RD_E = '0;
    ForwardA_E = 2'd0; ForwardB_E = 2'd0; ResultW = '0;
  endtask

  // Runs one MUL in E from its first cycle to the M write; checks stall length,
  // bubbles during the stall, that operands are captured at start, and the result.
  task automatic runMul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp, input string name);
    int n;
    int bad;
    ALUControlE = OP_MUL; RD1_E = a; RD2_E = b; ALUSrcE = 1'b0;
    ForwardA_E = 2'd0; ForwardB_E = 2'd0; RegWriteE = 1'b1; MemWriteE = 1'b0; RD_E = 5'd5;
    #1;
    chk({name, "_start_stall"}, 32'(StallE), 32'd1);
    n = 0;
    bad = 0;
    while (StallE === 1'b1 && n < 100) begin
      n++;
      step();
      if (n == 1) begin
        RD1_E = 32'd99; RD2_E = 32'd77; ForwardA_E = 2'd1; ResultW = 32'd55;
      end
      if (RegWriteM !== 1'b0 || RD_M !== '0 || ALU_ResultM !== '0) bad++;
    end
    chk({name, "_stall_cycles"}, 32'(n), 32'(XLEN + 1));
    chk({name, "_bubbles"}, 32'(bad), 32'd0);
    step();
    chk({name, "_result"}, ALU_ResultM, exp);
    chk({name, "_regwrite"}, 32'(RegWriteM), 32'd1);
    chk({name, "_rd"}, 32'(RD_M), 32'd5);
    ForwardA_E = 2'd0;
  endtask

  // Reference model: architectural semantics straight from the op definitions.
  function automatic logic [XLEN-1:0] refAlu(input logic [3:0] op, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      OP_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLL: return a << sh;
      OP_SRL: return a >> sh;
      OP_MUL: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic refTaken(input logic [2:0] bt, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    case (bt)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] refFwd(input logic [1:0] sel, input logic [XLEN-1:0] rd,
                                             input logic [XLEN-1:0] w, input logic [XLEN-1:0] m);
    if (sel == 2'd1) return w;
    if (sel == 2'd2) return m;
    return rd;
  endfunction

  typedef struct {
    logic [3:0]      op;
    logic [1:0]      fa;
    logic [1:0]      fb;
    logic            aluSrc;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] exp;
  } vec_t;

  typedef struct {
    logic [2:0] bt;
    logic       br;
    logic       jmp;
    logic       exp;
  } brVec_t;

  vec_t   vecs[16];
  brVec_t brVecs[10];

  // random-phase state
  logic [3:0]      rOp;
  logic [1:0]      rFa, rFb, rResSrc;
  logic            rAluSrc, rBr, rJmp, rRegW, rMemW;
  logic [2:0]      rBt;
  logic [XLEN-1:0] rA, rB, rImm, rW, rPc, rPc4, mSrcA, mFwdB, mSrcB, mRes, mWd, modelAluM;
  logic [REG_AW-1:0] rRd;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{OP_ADD, 2'd0, 2'd0, 1'b0, 32'd7,        32'd0,  32'd0,  32'd7};
    vecs[1]  = '{OP_ADD, 2'd2, 2'd0, 1'b0, 32'd5,        32'd1,  32'd0,  32'd8};
    vecs[2]  = '{OP_ADD, 2'd1, 2'd0, 1'b0, 32'd5,        32'd1,  32'd0,  32'd10};
    vecs[3]  = '{OP_ADD, 2'd0, 2'd0, 1'b0, 32'd5,        32'd1,  32'd0,  32'd6};
    vecs[4]  = '{OP_ADD, 2'd3, 2'd0, 1'b0, 32'd5,        32'd1,  32'd0,  32'd6};
    vecs[5]  = '{OP_SUB, 2'd0, 2'd0, 1'b0, 32'd5,        32'd7,  32'd0,  32'hFFFF_FFFE};
    vecs[6]  = '{OP_AND, 2'd0, 2'd0, 1'b0, 32'h0000F0F0, 32'h0FF0, 32'd0, 32'h0000_00F0};
    vecs[7]  = '{OP_OR,  2'd0, 2'd0, 1'b0, 32'h0000F0F0, 32'h0FF0, 32'd0, 32'h0000_FFF0};
    vecs[8]  = '{OP_XOR, 2'd0, 2'd0, 1'b0, 32'h0000F0F0, 32'h0FF0, 32'd0, 32'h0000_FF00};
    vecs[9]  = '{OP_SLT, 2'd0, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0,  32'd1};
    vecs[10] = '{OP_SLT, 2'd0, 2'd0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0,  32'd0};
    vecs[11] = '{OP_SLL, 2'd0, 2'd0, 1'b1, 32'd1,        32'd0,  32'd33, 32'd2};
    vecs[12] = '{OP_SRL, 2'd0, 2'd0, 1'b0, 32'h8000_0000, 32'd31, 32'd0, 32'd1};
    vecs[13] = '{4'd9,   2'd0, 2'd0, 1'b0, 32'd5,        32'd3,  32'd0,  32'd0};
    vecs[14] = '{OP_SUB, 2'd0, 2'd1, 1'b0, 32'd20,       32'd0,  32'd0,  32'd11};
    vecs[15] = '{OP_ADD, 2'd0, 2'd2, 1'b0, 32'd1,        32'd0,  32'd0,  32'd12};

    brVecs[0] = '{3'd4, 1'b1, 1'b0, 1'b1};
    brVecs[1] = '{3'd6, 1'b1, 1'b0, 1'b0};
    brVecs[2] = '{3'd5, 1'b1, 1'b0, 1'b0};
    brVecs[3] = '{3'd7, 1'b1, 1'b0, 1'b1};
    brVecs[4] = '{3'd0, 1'b1, 1'b0, 1'b0};
    brVecs[5] = '{3'd1, 1'b1, 1'b0, 1'b1};
    brVecs[6] = '{3'd2, 1'b1, 1'b0, 1'b0};
    brVecs[7] = '{3'd3, 1'b1, 1'b0, 1'b0};
    brVecs[8] = '{3'd1, 1'b0, 1'b0, 1'b0};
    brVecs[9] = '{3'd0, 1'b0, 1'b1, 1'b1};

    // Reset with non-zero E inputs so the cleared M state is meaningful.
    clearInputs();
    rst = 1'b1;
    RegWriteE = 1'b1; MemWriteE = 1'b1; RD1_E = 32'd5; RD2_E = 32'd3; RD_E = 5'd9;
    PCPlus4E = 32'h44; ResultSrcE = 2'd2;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("reset_stall", 32'(StallE), 32'd0);
    chk("reset_ctrlM", {27'd0, RegWriteM, MemWriteM, ResultSrcM, 1'b0}, 32'd0);
    chk("reset_rdM", 32'(RD_M), 32'd0);
    chk("reset_dataM", ALU_ResultM | WriteDataM | PCPlus4M, 32'd0);

    // Table-driven ALU / forwarding vectors.
    clearInputs();
    ResultW = 32'd9;
    RegWriteE = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ALUControlE = vecs[i].op; ForwardA_E = vecs[i].fa; ForwardB_E = vecs[i].fb;
      ALUSrcE = vecs[i].aluSrc; RD1_E = vecs[i].a; RD2_E = vecs[i].b; Imm_Ext_E = vecs[i].imm;
      RD_E = 5'(i);
      step();
      chk($sformatf("alu_vec%0d", i), ALU_ResultM, vecs[i].exp);
    end

    // Branch compares (combinational).
    clearInputs();
    RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1; PCE = 32'h100; Imm_Ext_E = 32'h20;
    for (int i = 0; i < 10; i++) begin
      BranchTypeE = brVecs[i].bt; BranchE = brVecs[i].br; JumpE = brVecs[i].jmp;
      #1;
      chk($sformatf("branch_vec%0d", i), 32'(PCSrcE), 32'(brVecs[i].exp));
    end
    chk("pc_target", PCTargetE, 32'h120);
    BranchE = 1'b0; JumpE = 1'b0;
    step();

    // Multiplier: single, wrap-around, then back-to-back.
    clearInputs();
    runMul(32'd6, 32'd7, 32'd42, "mul_6x7");
    runMul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, "mul_wrap");
    runMul(32'd3, 32'd4, 32'd12, "mul_b2b");

    // Reset ten cycles into a MUL.
    clearInputs();
    ALUControlE = OP_MUL; RD1_E = 32'd6; RD2_E = 32'd7; RegWriteE = 1'b1; RD_E = 5'd3;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    ALUControlE = OP_ADD; RD1_E = 32'd2; RD2_E = 32'd3;
    step();
    rst = 1'b0;
    #1;
    chk("rstmul_stall", 32'(StallE), 32'd0);
    chk("rstmul_ctrlM", {28'd0, RegWriteM, MemWriteM, ResultSrcM}, 32'd0);
    chk("rstmul_dataM", ALU_ResultM | WriteDataM | PCPlus4M | 32'(RD_M), 32'd0);
    step();
    chk("rstmul_add", ALU_ResultM, 32'd5);

    // Store-data forwarding from M.
    clearInputs();
    RD1_E = 32'h0000_DEAD;
    step();
    MemWriteE = 1'b1; ForwardB_E = 2'd2; ALUSrcE = 1'b1; Imm_Ext_E = 32'd4; RD2_E = 32'h1234;
    step();
    chk("store_wdata", WriteDataM, 32'h0000_DEAD);
    chk("store_memwrite", 32'(MemWriteM), 32'd1);
    chk("store_addr", ALU_ResultM, 32'h0000_DEB1);

    // Randomized transactions against the reference model.
    clearInputs();
    step();
    modelAluM = '0;
    for (int t = 0; t < 200; t++) begin
      int n;
      rOp = ($urandom_range(0, 4) == 0) ? OP_MUL : 4'($urandom_range(0, 15));
      rFa = 2'($urandom); rFb = 2'($urandom); rAluSrc = 1'($urandom);
      rA = $urandom; rB = ($urandom_range(0, 3) == 0) ? rA : $urandom;
      rImm = $urandom; rW = $urandom; rPc = $urandom; rPc4 = $urandom;
      rBt = 3'($urandom); rBr = 1'($urandom); rJmp = ($urandom_range(0, 7) == 0);
      rRegW = 1'($urandom); rMemW = 1'($urandom); rResSrc = 2'($urandom); rRd = 5'($urandom);

      ALUControlE = rOp; ForwardA_E = rFa; ForwardB_E = rFb; ALUSrcE = rAluSrc;
      RD1_E = rA; RD2_E = rB; Imm_Ext_E = rImm; ResultW = rW; PCE = rPc; PCPlus4E = rPc4;
      BranchTypeE = rBt; BranchE = rBr; JumpE = rJmp;
      RegWriteE = rRegW; MemWriteE = rMemW; ResultSrcE = rResSrc; RD_E = rRd;

      mSrcA = refFwd(rFa, rA, rW, modelAluM);
      mFwdB = refFwd(rFb, rB, rW, modelAluM);
      mSrcB = rAluSrc ? rImm : mFwdB;
      mRes  = refAlu(rOp, mSrcA, mSrcB);
      #1;
      chk($sformatf("rnd%0d_pcsrc", t), 32'(PCSrcE), 32'((rBr && refTaken(rBt, mSrcA, mFwdB)) || rJmp));
      chk($sformatf("rnd%0d_pctarget", t), PCTargetE, rPc + rImm);

      if (rOp == OP_MUL) begin
        n = 0;
        while (StallE === 1'b1 && n < 100) begin
          n++;
          step();
        end
        chk($sformatf("rnd%0d_mulstall", t), 32'(n), 32'(XLEN + 1));
        // M holds a bubble at the final cycle, so a forward from M reads 0.
        mWd = refFwd(rFb, rB, rW, 32'd0);
      end else begin
        mWd = mFwdB;
      end
      step();
      chk($sformatf("rnd%0d_alu", t), ALU_ResultM, mRes);
      chk($sformatf("rnd%0d_wdata", t), WriteDataM, mWd);
      chk($sformatf("rnd%0d_ctrl", t),
          {18'd0, RegWriteM, MemWriteM, ResultSrcM, RD_M, 5'd0},
          {18'd0, rRegW, rMemW, rResSrc, rRd, 5'd0});
      chk($sformatf("rnd%0d_pc4", t), PCPlus4M, rPc4);
      modelAluM = mRes;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage_fwd.md
Name: execute_stage_fwd

Overview:
- Parametrised successor to the single-cycle execute stage of the 5-stage RISC-V pipeline.
- Adds operand forwarding muxes, a full set of conditional branch compares, an extended ALU op set, and an iterative multi-cycle multiplier.
- The multiplier stalls the pipeline and inserts bubbles into the E->M register.
- Sits between the decode-to-execute register and the memory stage, and drives a stall back to the hazard unit.

Parameters:
- XLEN, 32, datapath and PC width.
- REG_AW, 5, register-index width.
- MUL_EN, 1, 1 instantiates the multiplier; 0 decodes MUL as ADD with no stall.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE  in  1 each  decoded controls.
- ResultSrcE  in  2  writeback select.
- ALUControlE  in  4  ALU op (codes in package).
- BranchTypeE  in  3  funct3 compare type.
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  XLEN each  operands and PCs.
- RD_E  in  REG_AW  destination register.
- ForwardA_E, ForwardB_E  in  2 each  00 = RDx_E, 01 = ResultW, 10 = ALU_ResultM, 11 = RDx_E.
- ResultW  in  XLEN  writeback value.
- PCSrcE  out  1  redirect PC.
- PCTargetE  out  XLEN  PCE + Imm_Ext_E.
- StallE  out  1  hold F/D/E.
- RegWriteM, MemWriteM  out  1 each.
- ResultSrcM  out  2.
- RD_M  out  REG_AW.
- PCPlus4M, WriteDataM, ALU_ResultM  out  XLEN each  registered M-stage values.

Behaviour:
- **Reset.** rst is synchronous and active-high. All M outputs are 0, the multiplier FSM is IDLE, and StallE is 0 in the cycle after rst.
- **Forwarding.** SrcA = fwd(ForwardA_E, RD1_E). FwdB = fwd(ForwardB_E, RD2_E). SrcB = ALUSrcE ? Imm_Ext_E : FwdB. WriteDataE = FwdB (forwarded store data).
- **ALU ops.** ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101 (signed), SLL 0110, SRL 0111, MUL 1000.
  - Arithmetic is modulo 2^XLEN.
  - Shift amount is SrcB[$clog2(XLEN)-1:0].
  - Unused codes produce 0.
- **Branch compare** on SrcA vs FwdB:
  - BranchTypeE 000 eq, 001 ne, 100 lt (signed), 101 ge (signed), 110 ltu, 111 geu.
  - 010 and 011 are never taken.
  - PCSrcE = (BranchE & cond) | JumpE, purely combinational, and not gated by StallE.
- **Multiplier FSM** (MUL_EN=1, active when ALUControlE == MUL):
  - IDLE:
    - With MUL present: latch SrcA/SrcB, clear accumulator, count = XLEN, go to BUSY. StallE = 1.
    - Otherwise: StallE = 0.
  - BUSY:
    - Each cycle: if mcand_lsb then acc += mplier. Then mplier <<= 1, mcand >>= 1, count--.
    - When count reaches 1 after the update, go to DONE.
    - StallE = 1.
  - DONE: ALU result = acc (low XLEN bits), StallE = 0, go to IDLE.
  - Latency: a MUL occupies E for XLEN+2 cycles; StallE is high for XLEN+1 consecutive cycles.
  - Operands are captured at IDLE, so later changes on the forwarding inputs during the stall are ignored.
- **E->M register.**
  - When StallE = 1: load a bubble. RegWriteM = 0, MemWriteM = 0, RD_M = 0, ResultSrcM = 0, and data fields = 0.
  - Otherwise: load the E values.
- **Reset mid-multiply.** rst returns the FSM to IDLE and clears the accumulator; no partial result reaches M.
- **Back-to-back MULs.** The second MUL enters E in the cycle after DONE and starts a fresh IDLE load; there are no idle gaps beyond that.
- **MUL_EN = 0.** Code 1000 behaves as ADD and StallE is tied to 0.

Decomposition:
- Shared package exe_pkg holds:
  - ALU op codes.
  - Forward-select codes.
  - Branch-type codes.
  - The bubble constant.
- One sub-module, mul_iter: start/done handshake, XLEN-parametrised shift-add multiplier, state register and counter.
- ALU, forwarding mux and comparator stay inline.

Test Plan:
- **Forwarding.** Set RD1_E = 5, ALU_ResultM = 7, ResultW = 9, ALU ADD, ALUSrcE = 0, RD2_E = 1.
  - ForwardA = 10 -> ALU_ResultM = 8 next cycle.
  - ForwardA = 01 -> 10.
  - ForwardA = 00 -> 6.
- **Branches.**
  - SrcA = 0xFFFFFFFF, FwdB = 1, BranchE = 1: blt -> PCSrcE = 1; bltu -> 0; bge -> 0; bgeu -> 1.
  - PCE = 0x100, Imm = 0x20 -> PCTargetE = 0x120.
- **MUL stall.** MUL 6 × 7 at XLEN = 32.
  - StallE high for exactly 33 cycles.
  - The M stage shows RegWriteM = 0 bubbles during the stall.
  - Then ALU_ResultM = 42 with RegWriteM = 1 and RD_M = RD_E.
- **Wrap-around.** MUL 0xFFFFFFFF × 0xFFFFFFFF -> ALU_ResultM = 0x00000001.
  - Back-to-back MUL 3 × 4 -> 12, starting in the cycle after DONE.
- **Reset mid-operation.** Assert rst 10 cycles into a MUL.
  - Next cycle: StallE = 0 and all M outputs = 0.
  - A following ADD 2 + 3 gives ALU_ResultM = 5 one cycle later.
- **Store data forwarding.** MemWriteE = 1, ForwardB = 10, ALU_ResultM = 0xDEAD, ALUSrcE = 1 -> WriteDataM = 0xDEAD, MemWriteM = 1.
